// File: rtl/sd_cmd_engine_pkg.sv
// Shared types and helpers for the SD CMD-line engine: response encodings,
// FSM states, frame lengths and the CRC7 (x^7+x^3+1) bit-step function.
package sd_cmd_pkg;

   typedef enum logic [1:0] {
      RESP_NONE = 2'b00,
      RESP_R1   = 2'b01,
      RESP_R2   = 2'b10,
      RESP_R3   = 2'b11
   } resp_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_START,
      ST_RECV,
      ST_GAP,
      ST_DONE
   } state_t;

   localparam logic [6:0] CRC7_POLY = 7'h09;
   localparam int         CMD_LEN   = 48;
   localparam int         R2_LEN    = 136;

   function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
      logic fb;
      fb = crc[6] ^ b;
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_cmd_engine_clk_gen.sv
// SD clock divider: runs only while enabled, toggles sd_clk at terminal count
// and flags the rising/falling edge cycles. Macro SD_CMD_HIGH_SPEED_EN adds fast.
module sd_clk_gen
   import sd_cmd_pkg::*;
#(
   parameter int HALF_PERIOD = 63
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
`ifdef SD_CMD_HIGH_SPEED_EN
   input  logic fast,
`endif
   output logic sd_clk,
   output logic rise_tick,
   output logic fall_tick
);

   localparam logic [15:0] HP_LAST = 16'(HALF_PERIOD - 1);

   logic [15:0] div_reg;
   logic [15:0] limit;
   logic        terminal;

`ifdef SD_CMD_HIGH_SPEED_EN
   assign limit = fast ? 16'd0 : HP_LAST;
`else
   assign limit = HP_LAST;
`endif

   assign terminal  = en && (div_reg == limit);
   assign rise_tick = terminal && !sd_clk;
   assign fall_tick = terminal && sd_clk;

   always_ff @(posedge clk) begin
      if (reset || !en) begin
         div_reg <= '0;
         sd_clk  <= 1'b0;
      end else if (terminal) begin
         div_reg <= '0;
         sd_clk  <= ~sd_clk;
      end else begin
         div_reg <= div_reg + 16'd1;
      end
   end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sends one 48-bit command with CRC7, captures an optional
// 48/136-bit response. Macro SD_CMD_HIGH_SPEED_EN adds the fast_mode input.
module sd_cmd_engine
   import sd_cmd_pkg::*;
#(
   parameter int HALF_PERIOD  = 63,
   parameter int RESP_TIMEOUT = 64,
   parameter int GAP_CLKS     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [5:0]   cmd_index,
   input  logic [31:0]  cmd_arg,
   input  logic [1:0]   resp_type,
`ifdef SD_CMD_HIGH_SPEED_EN
   input  logic         fast_mode,
`endif
   output logic         busy,
   output logic         done,
   output logic         timeout,
   output logic         crc_err,
   output logic [5:0]   resp_index,
   output logic [127:0] resp_data,
   output logic         sd_clk,
   output logic         sd_cmd_o,
   output logic         sd_cmd_oe,
   input  logic         sd_cmd_i
);

   localparam logic [7:0] TO_LAST  = 8'(RESP_TIMEOUT - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CLKS - 1);

   state_t       state_reg;
   resp_t        rtype_reg;
   logic [47:0]  tx_reg;
   logic [5:0]   bit_cnt_reg;
   logic [7:0]   cnt_reg;
   logic [7:0]   rx_left_reg;
   logic [127:0] rx_sr_reg;
   logic [6:0]   rx_crc_reg;
   logic         rise_tick;
   logic         fall_tick;

   logic [39:0]  hdr;
   logic [6:0]   frame_crc;
   logic [7:0]   rx_idx;
   logic [127:0] rx_next;

   assign hdr     = {2'b01, cmd_index, cmd_arg};
   assign rx_idx  = rx_left_reg - 8'd1;
   assign rx_next = {rx_sr_reg[126:0], sd_cmd_i};

   always_comb begin
      frame_crc = '0;
      for (int i = 39; i >= 0; i--) frame_crc = crc7_next(frame_crc, hdr[i]);
   end

`ifdef SD_CMD_HIGH_SPEED_EN
   logic fast_reg;
   always_ff @(posedge clk) begin
      if (reset) fast_reg <= 1'b0;
      else if (state_reg == ST_IDLE && start) fast_reg <= fast_mode;
   end
`endif

   sd_clk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_clk_gen (
      .clk       (clk),
      .reset     (reset),
      .en        (busy),
`ifdef SD_CMD_HIGH_SPEED_EN
      .fast      (fast_reg),
`endif
      .sd_clk    (sd_clk),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         rtype_reg   <= RESP_NONE;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         crc_err     <= 1'b0;
         resp_index  <= '0;
         resp_data   <= '0;
         sd_cmd_o    <= 1'b1;
         sd_cmd_oe   <= 1'b0;
         tx_reg      <= '0;
         bit_cnt_reg <= '0;
         cnt_reg     <= '0;
         rx_left_reg <= '0;
         rx_sr_reg   <= '0;
         rx_crc_reg  <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  rtype_reg   <= resp_t'(resp_type);
                  tx_reg      <= {hdr, frame_crc, 1'b1};
                  bit_cnt_reg <= 6'd47;
                  sd_cmd_o    <= hdr[39];
                  sd_cmd_oe   <= 1'b1;
                  busy        <= 1'b1;
                  timeout     <= 1'b0;
                  crc_err     <= 1'b0;
                  state_reg   <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (fall_tick) begin
                  if (bit_cnt_reg == 6'd0) begin
                     sd_cmd_oe <= 1'b0;
                     sd_cmd_o  <= 1'b1;
                     cnt_reg   <= '0;
                     state_reg <= (rtype_reg == RESP_NONE) ? ST_GAP : ST_WAIT_START;
                  end else begin
                     sd_cmd_o    <= tx_reg[bit_cnt_reg - 6'd1];
                     bit_cnt_reg <= bit_cnt_reg - 6'd1;
                  end
               end
            end
            ST_WAIT_START: begin
               if (rise_tick) begin
                  if (!sd_cmd_i) begin
                     rx_left_reg <= (rtype_reg == RESP_R2) ? 8'd135 : 8'd47;
                     rx_crc_reg  <= '0;
                     rx_sr_reg   <= '0;
                     state_reg   <= ST_RECV;
                  end else if (cnt_reg == TO_LAST) begin
                     timeout   <= 1'b1;
                     cnt_reg   <= '0;
                     state_reg <= ST_GAP;
                  end else begin
                     cnt_reg <= cnt_reg + 8'd1;
                  end
               end
            end
            ST_RECV: begin
               if (rise_tick) begin
                  rx_sr_reg   <= rx_next;
                  rx_left_reg <= rx_left_reg - 8'd1;
                  // R2 header bits 135:128 sit outside the CRC window.
                  if (rx_idx >= 8'd8 && rx_idx <= 8'd127)
                     rx_crc_reg <= crc7_next(rx_crc_reg, sd_cmd_i);
                  if (rx_left_reg == 8'd1) begin
                     if (rtype_reg == RESP_R2) begin
                        resp_data <= rx_next;
                     end else begin
                        resp_data  <= {96'd0, rx_next[39:8]};
                        resp_index <= rx_next[45:40];
                     end
                     crc_err   <= !sd_cmd_i ||
                                  (rtype_reg != RESP_R3 && rx_crc_reg != rx_next[7:1]);
                     cnt_reg   <= '0;
                     state_reg <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (rise_tick) begin
                  if (cnt_reg == GAP_LAST) begin
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state_reg <= ST_DONE;
                  end else begin
                     cnt_reg <= cnt_reg + 8'd1;
                  end
               end
            end
            ST_DONE: begin
               done      <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/sd_cmd_engine.md
Name: sd_cmd_engine

Overview:
- Hardware SD-card CMD-line engine that replaces software bit-banging of the SD clock and command pins.
- Serialises one 48-bit command frame with CRC7 and generates the SD clock.
- Captures the optional 48-bit or 136-bit response and reports done, timeout and CRC status.
- Sits between a CPU-facing register slave and the SD_CLK/SD_CMD pad tri-state at top level.

Parameters:
- HALF_PERIOD, 63, system clocks per SD-clock half period (63 at 50 MHz gives ≈397 kHz).
- RESP_TIMEOUT, 64, SD rising edges to wait for a response start bit (Ncr limit).
- GAP_CLKS, 8, SD clocks after the end bit before done (Ncc).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; accepted only when busy=0
- cmd_index  in  6  command index
- cmd_arg  in  32  command argument
- resp_type  in  2  00 none, 01 48-bit with CRC, 10 136-bit (R2), 11 48-bit without CRC (R3)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- timeout  out  1  sticky until next start; no start bit seen
- crc_err  out  1  sticky until next start; response CRC7 mismatch
- resp_index  out  6  bits 45:40 of a 48-bit response
- resp_data  out  128  48-bit response: [31:0] = bits 39:8, upper bits 0; R2: bits 127:0 of the frame (CRC in [7:1])
- sd_clk  out  1  SD clock
- sd_cmd_o  out  1  CMD drive value
- sd_cmd_oe  out  1  CMD output enable
- sd_cmd_i  in  1  CMD pad input

Behaviour:
- Reset values: sd_clk=0, sd_cmd_o=1, sd_cmd_oe=0, busy=0, done=0, timeout=0, crc_err=0, resp_index=0, resp_data=0, FSM=IDLE, divider=0.
- Reset mid-operation: abort in the same cycle, release CMD, stop the clock, emit no done pulse.
- Divider: counts 0..HALF_PERIOD-1 only while busy; at terminal count sd_clk toggles.
  - rise_tick = terminal & sd_clk=0.
  - fall_tick = terminal & sd_clk=1.
  - In IDLE: divider=0, sd_clk=0.
- Drive on fall_tick (first bit driven on entry to SEND); sample sd_cmd_i on rise_tick.
- Frame: 0, 1, cmd_index, cmd_arg, CRC7, 1, MSB first.
  - CRC7 polynomial is x^7+x^3+1, initial 0, computed over frame bits 47:8.
- start while busy is ignored.
- On an accepted start: latch inputs, clear timeout and crc_err, go to SEND.
- FSM states and transitions:
  - IDLE: on start, go to SEND.
  - SEND: sd_cmd_oe=1; shift 48 bits, one per fall_tick. On the fall_tick after bit 0, set oe=0. Then go to GAP if resp_type=00, else WAIT_START.
  - WAIT_START: count rise_ticks.
    - sd_cmd_i=0 sampled: go to RECV (start bit counts as received).
    - RESP_TIMEOUT rise_ticks with no 0: set timeout=1 and go to GAP.
  - RECV: shift 47 more bits (48-bit response) or 135 more (R2). Run the receive CRC.
    - 48-bit response: CRC over bits 47:8.
    - R2: CRC over bits 127:8, then compared with bits 7:1.
    - Set crc_err on mismatch when resp_type is 01 or 10; never for 11.
    - Bad end bit (0) also sets crc_err.
    - Then go to GAP.
  - GAP: GAP_CLKS rise_ticks with CMD released, then DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- A start asserted in the DONE cycle is ignored.
- resp_data and resp_index update only at RECV completion. On timeout they keep their previous values.

Optional Feature:
- SD_CMD_HIGH_SPEED_EN
  - Defined: adds input fast_mode (1 bit), sampled at start. fast_mode=1 uses half period 1 (25 MHz at 50 MHz) for that whole command.
  - Undefined: port absent; HALF_PERIOD always used.

Decomposition:
- Package sd_cmd_pkg: resp_type encodings, FSM state enum, CRC7 polynomial constant, frame lengths 48/136.
- Function crc7_next(crc, bit) lives in the package.
- One sub-module, sd_clk_gen: divider plus rise/fall tick generation, with an enable input.
- Shift/FSM logic stays in sd_cmd_engine.

Test Plan:
- CMD0, arg 0, resp_type 00 -> wire shows 0x400000000095.
  - oe high for exactly 48 SD clocks, done after 8 gap clocks, timeout=0.
- CMD8, arg 0x000001AA, resp_type 01; card model answers 0x08000001AA13 after 5 clocks -> first 40 bits on wire 0x48000001AA with CRC byte 0x87; resp_index=8, resp_data=0x000001AA, crc_err=0.
- Same as previous, with one flipped bit in the response arg -> crc_err=1, done pulses once.
- CMD55, resp_type 01, CMD held high -> timeout=1 after 64 rise_ticks plus 8 gap clocks; resp_data unchanged.
- CMD2, resp_type 10, 136-bit response with valid CRC -> resp_data equals bits 127:0, crc_err=0.
- ACMD41, resp_type 11, response with a garbage CRC -> crc_err=0.
- Assert reset mid-SEND -> next cycle: oe=0, sd_clk=0, busy=0, no done.
- Start pulsed while busy -> ignored.
